// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button debouncer.
// Cycle defaults assume a 27 MHz system clock.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_27M = 270_000;     // 10 ms
  localparam int unsigned LONG_CYCLES_27M     = 27_000_000;  // 1 s

  // Width of a counter that must hold values 0 .. terminal-1.
  function automatic int unsigned cnt_width(input int unsigned terminal);
    return (terminal < 2) ? 1 : $clog2(terminal);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, optional long-press
// counter (built only when BTN_LONG_PRESS_EN is defined).
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_27M,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_27M
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          sample;
  btn_state_t    state;
  btn_state_t    state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          level_n;
  logic          press_n;
  logic          release_n;

  // Pins idle high, so the chain resets to "released" to avoid a false press.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  assign sample = ~sync_b;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    level_n   = level;
    press_n   = 1'b0;
    release_n = 1'b0;
    case (state)
      IDLE: begin
        if (sample) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sample) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
          level_n = 1'b1;
          press_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!sample) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sample) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n   = IDLE;
          cnt_n     = '0;
          level_n   = 1'b0;
          release_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        level_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      level         <= level_n;
      press         <= press_n;
      release_pulse <= release_n;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned LW = cnt_width(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_FIRE = LW'(LONG_CYCLES - 2);

  logic [LW-1:0] long_cnt;

  // Saturating at LONG_LAST gives exactly one pulse per hold; release-wait
  // bounces leave the count alone so a shaky release cannot re-arm it.
  always_ff @(posedge clk) begin
    if (rst) begin
      long_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (press_n) begin
        long_cnt <= '0;
      end else if (state == PRESSED && long_cnt != LONG_LAST) begin
        long_cnt   <= long_cnt + 1'b1;
        long_press <= (long_cnt == LONG_FIRE);
      end
    end
  end
`else
  logic unused_long_cfg;
  assign unused_long_cfg = |LONG_CYCLES;
  assign long_press      = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Debounced front end for N_BTN active-low push-buttons; optional long-press
// pulse enabled by BTN_LONG_PRESS_EN. The release pulse port is release_pulse
// because "release" is a reserved word.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_27M,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_27M
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .btn           (btn[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .long_press    (long_press[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn;
  logic [1:0] level;
  logic [1:0] press;
  logic [1:0] release_pulse;
  logic [1:0] long_press;

  int checks   = 0;
  int failures = 0;

`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  btn_debounce #(
    .N_BTN           (2),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn           (btn),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] l, input logic [1:0] p,
                           input logic [1:0] r, input logic [1:0] lp);
    check({tag, ".level"},      32'(level),         32'(l));
    check({tag, ".press"},      32'(press),         32'(p));
    check({tag, ".release"},    32'(release_pulse), 32'(r));
    check({tag, ".long_press"}, 32'(long_press),    32'(lp));
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    btn = 2'b11;
    tick();
    tick();
    check_out("reset", 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;

    // Clean press on channel 0: captured at edge k, press at k+6 (7th tick).
    btn[0] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_out($sformatf("press0_t%0d", i), (i == 7) ? 2'b01 : 2'b00,
                (i == 7) ? 2'b01 : 2'b00, 2'b00, 2'b00);
    end
    tick();
    check_out("press0_hold", 2'b01, 2'b00, 2'b00, 2'b00);

    // Release channel 0: mirror latency.
    btn[0] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_out($sformatf("rel0_t%0d", i), (i == 7) ? 2'b00 : 2'b01,
                2'b00, (i == 7) ? 2'b01 : 2'b00, 2'b00);
    end
    tick();
    check_out("rel0_idle", 2'b00, 2'b00, 2'b00, 2'b00);

    // Bounce: 3-cycle lows never survive the 4-cycle debounce.
    for (int r = 0; r < 5; r++) begin
      btn[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        check_out($sformatf("bounce%0d_lo%0d", r, i), 2'b00, 2'b00, 2'b00, 2'b00);
      end
      btn[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        check_out($sformatf("bounce%0d_hi%0d", r, i), 2'b00, 2'b00, 2'b00, 2'b00);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("bounce_settle%0d", i), 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Simultaneous press on both channels.
    btn = 2'b00;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_out($sformatf("both_t%0d", i), (i == 7) ? 2'b11 : 2'b00,
                (i == 7) ? 2'b11 : 2'b00, 2'b00, 2'b00);
    end

    // Long hold: one long_press pulse 15 cycles after press, no repeat.
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_out($sformatf("long_t%0d", i), 2'b11, 2'b00, 2'b00,
                (LONG_EN && i == 15) ? 2'b11 : 2'b00);
    end

    btn = 2'b11;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_out($sformatf("both_rel_t%0d", i), (i == 7) ? 2'b00 : 2'b11,
                2'b00, (i == 7) ? 2'b11 : 2'b00, 2'b00);
    end
    tick();

    // Reset while channel 0 is held: outputs clear, then a fresh press.
    btn[0] = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    check_out("rstmid_pressed", 2'b01, 2'b01, 2'b00, 2'b00);
    tick();
    rst = 1'b1;
    tick();
    check_out("rstmid_in_reset", 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_out($sformatf("rstmid_t%0d", i), (i == 7) ? 2'b01 : 2'b00,
                (i == 7) ? 2'b01 : 2'b00, 2'b00, 2'b00);
    end
    tick();
    check_out("rstmid_hold", 2'b01, 2'b00, 2'b00, 2'b00);

    btn = 2'b11;
    for (int i = 0; i < 8; i++) tick();
    check_out("final_idle", 2'b00, 2'b00, 2'b00, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
